fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_fetch_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, 1-cycle imem interface and the FD pipeline register.
// Define RV32C_EN to fetch 16-bit parcels and 32-bit instructions straddling words.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        F_stall_i,
    input  logic        D_flush_i,
    input  logic        D_predictPC_i,
    input  logic [31:0] D_PCprediction_i,
    input  logic        E_correctPC_i,
    input  logic [31:0] E_PCcorrection_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] FD_PC_o,
    output logic [31:0] FD_instr_o,
    output logic        FD_isRV32C_o,
    output logic        FD_nop_o
);

`ifdef RV32C_EN
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
`else
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif
    localparam logic [31:0] NOP     = 32'h0000_0033;
    localparam logic [31:0] PC_INIT = RESET_PC & PC_MASK;

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] redirect_pc;
    logic        redirect;
    logic        fetch_valid;
    logic        bubble;
    logic [31:0] fd_pc_d;
    logic [31:0] fd_instr_d;
    logic        fd_nop_d;

    // Execute-stage correction outranks the decode-stage prediction
    assign redirect    = E_correctPC_i | D_predictPC_i;
    assign redirect_pc = (E_correctPC_i ? E_PCcorrection_i
                                        : D_PCprediction_i) & PC_MASK;
    assign imem_addr_o = reset_i ? {PC_INIT[31:2], 2'b00}
                                 : {next_pc[31:2], 2'b00};

`ifdef RV32C_EN
    logic [15:0] parcel;
    logic        is_c;
    logic [15:0] spill;
    logic [15:0] spill_d;
    logic [31:0] spill_pc;
    logic [31:0] spill_pc_d;
    logic        spill_valid;
    logic        spill_valid_d;
    logic        fd_c;
    logic        fd_c_d;

    assign parcel       = pc[1] ? imem_rdata_i[31:16] : imem_rdata_i[15:0];
    assign is_c         = parcel[1:0] != 2'b11;
    assign FD_isRV32C_o = fd_c;

    // Next PC, spill buffer and FD contents for the coming edge
    always_comb begin
        next_pc       = pc;
        spill_d       = spill;
        spill_pc_d    = spill_pc;
        spill_valid_d = spill_valid;
        fd_pc_d       = FD_PC_o;
        fd_instr_d    = FD_instr_o;
        fd_nop_d      = FD_nop_o;
        fd_c_d        = fd_c;
        bubble        = 1'b0;
        if (redirect) begin
            next_pc       = redirect_pc;
            spill_valid_d = 1'b0;
            bubble        = 1'b1;
        end else if (F_stall_i) begin
            next_pc = pc;
        end else if (!fetch_valid) begin
            bubble = 1'b1;
        end else if (spill_valid) begin
            fd_pc_d       = spill_pc;
            fd_instr_d    = {imem_rdata_i[15:0], spill};
            fd_nop_d      = 1'b0;
            fd_c_d        = 1'b0;
            spill_valid_d = 1'b0;
            next_pc       = pc + 32'd2;
        end else if (pc[1] && !is_c) begin
            spill_d       = parcel;
            spill_pc_d    = pc;
            spill_valid_d = 1'b1;
            bubble        = 1'b1;
            next_pc       = {pc[31:2] + 30'd1, 2'b00};
        end else begin
            fd_pc_d    = pc;
            fd_instr_d = is_c ? {16'h0000, parcel} : imem_rdata_i;
            fd_nop_d   = 1'b0;
            fd_c_d     = is_c;
            next_pc    = pc + (is_c ? 32'd2 : 32'd4);
        end
        if (bubble || D_flush_i) begin
            fd_nop_d   = 1'b1;
            fd_instr_d = NOP;
            fd_c_d     = 1'b0;
        end
    end

    // Upper half of a straddling instruction and the compressed flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            spill       <= '0;
            spill_pc    <= '0;
            spill_valid <= 1'b0;
            fd_c        <= 1'b0;
        end else begin
            spill       <= spill_d;
            spill_pc    <= spill_pc_d;
            spill_valid <= spill_valid_d;
            fd_c        <= fd_c_d;
        end
    end
`else
    assign FD_isRV32C_o = 1'b0;

    // Next PC and FD contents for the coming edge, words only
    always_comb begin
        next_pc    = pc;
        fd_pc_d    = FD_PC_o;
        fd_instr_d = FD_instr_o;
        fd_nop_d   = FD_nop_o;
        bubble     = 1'b0;
        if (redirect) begin
            next_pc = redirect_pc;
            bubble  = 1'b1;
        end else if (F_stall_i) begin
            next_pc = pc;
        end else if (!fetch_valid) begin
            bubble = 1'b1;
        end else begin
            fd_pc_d    = pc;
            fd_instr_d = imem_rdata_i;
            fd_nop_d   = 1'b0;
            next_pc    = pc + 32'd4;
        end
        if (bubble || D_flush_i) begin
            fd_nop_d   = 1'b1;
            fd_instr_d = NOP;
        end
    end
`endif

    // Fetch PC and the first-fetch flag (no data owed before first edge)
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc          <= PC_INIT;
            fetch_valid <= 1'b0;
        end else begin
            pc          <= next_pc;
            fetch_valid <= 1'b1;
        end
    end

    // FD pipeline register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            FD_PC_o    <= '0;
            FD_instr_o <= NOP;
            FD_nop_o   <= 1'b1;
        end else begin
            FD_PC_o    <= fd_pc_d;
            FD_instr_o <= fd_instr_d;
            FD_nop_o   <= fd_nop_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, compressed-fetch sequences and a
// randomized run against an instruction-stream reference model.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0033;
`ifdef RV32C_EN
    localparam logic [31:0] MASK = 32'hFFFF_FFFE;
`else
    localparam logic [31:0] MASK = 32'hFFFF_FFFC;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        F_stall_i;
    logic        D_flush_i;
    logic        D_predictPC_i;
    logic [31:0] D_PCprediction_i;
    logic        E_correctPC_i;
    logic [31:0] E_PCcorrection_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] FD_PC_o;
    logic [31:0] FD_instr_o;
    logic        FD_isRV32C_o;
    logic        FD_nop_o;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .F_stall_i        (F_stall_i),
        .D_flush_i        (D_flush_i),
        .D_predictPC_i    (D_predictPC_i),
        .D_PCprediction_i (D_PCprediction_i),
        .E_correctPC_i    (E_correctPC_i),
        .E_PCcorrection_i (E_PCcorrection_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rdata_i     (imem_rdata_i),
        .FD_PC_o          (FD_PC_o),
        .FD_instr_o       (FD_instr_o),
        .FD_isRV32C_o     (FD_isRV32C_o),
        .FD_nop_o         (FD_nop_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory: 2 KiB, aliased, one-cycle synchronous read
    logic [31:0] mem [512];
    always @(posedge clk_i) imem_rdata_i <= mem[imem_addr_o[10:2]];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] w);
        mem[a[10:2]] = w;
    endtask

    task automatic drive(input bit st, input bit fl, input bit dp,
                         input logic [31:0] dpt, input bit ec,
                         input logic [31:0] ect);
        F_stall_i        = st;
        D_flush_i        = fl;
        D_predictPC_i    = dp;
        D_PCprediction_i = dpt;
        E_correctPC_i    = ec;
        E_PCcorrection_i = ect;
    endtask

    task automatic idle();
        drive(0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic exp_nop(input string name);
        chk({name, ".nop"}, {31'd0, FD_nop_o}, 32'd1);
        chk({name, ".instr"}, FD_instr_o, NOP);
    endtask

    task automatic exp_fd(input string name, input logic [31:0] pc,
                          input logic [31:0] ins, input bit c);
        chk({name, ".nop"}, {31'd0, FD_nop_o}, 32'd0);
        chk({name, ".pc"}, FD_PC_o, pc);
        chk({name, ".instr"}, FD_instr_o, ins);
        chk({name, ".rvc"}, {31'd0, FD_isRV32C_o}, {31'd0, c});
    endtask

    // ---------------- reference model: instruction stream ----------------
    function automatic logic [15:0] parcel_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[10:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic bit wide_at(input logic [31:0] a);
`ifdef RV32C_EN
        logic [15:0] p;
        p = parcel_at(a);
        return p[1:0] == 2'b11;
`else
        return a[1:0] == 2'b00;
`endif
    endfunction

    function automatic logic [31:0] instr_at(input logic [31:0] a);
`ifdef RV32C_EN
        logic [15:0] p;
        p = parcel_at(a);
        if (p[1:0] != 2'b11) return {16'h0000, p};
        return {parcel_at(a + 32'd2), p};
`else
        return mem[a[10:2]];
`endif
    endfunction

    logic [31:0] m_cur;
    bit          m_started;
    bit          m_paid;
    bit          e_nop;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    bit          e_c;

    task automatic model_reset();
        m_cur     = RST_PC & MASK;
        m_started = 0;
        m_paid    = 0;
        e_nop     = 1;
        e_instr   = NOP;
        e_pc      = 32'h0;
        e_c       = 0;
    endtask

    // One clock edge: a redirect or the first fetch costs a bubble, a 32-bit
    // instruction at an odd halfword costs one more, otherwise one per edge.
    task automatic model_step(input bit st, input bit fl, input bit dp,
                              input logic [31:0] dpt, input bit ec,
                              input logic [31:0] ect);
        bit bub;
        bub = 0;
        if (ec || dp) begin
            m_cur  = (ec ? ect : dpt) & MASK;
            m_paid = 0;
            bub    = 1;
        end else if (st) begin
            bub = fl;
        end else if (!m_started) begin
            bub = 1;
        end else if (m_cur[1] && wide_at(m_cur) && !m_paid) begin
            bub    = 1;
            m_paid = 1;
        end else begin
            if (fl) begin
                bub = 1;
            end else begin
                e_nop   = 0;
                e_pc    = m_cur;
                e_instr = instr_at(m_cur);
                e_c     = !wide_at(m_cur);
            end
            m_cur  = m_cur + (wide_at(m_cur) ? 32'd4 : 32'd2);
            m_paid = 0;
        end
        if (bub) begin
            e_nop   = 1;
            e_instr = NOP;
        end
        m_started = 1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          st;
        bit          fl;
        bit          dp;
        logic [31:0] dpt;
        bit          ec;
        logic [31:0] ect;
        logic [31:0] addr;
        bit          nop;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t tbl [15];

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0000_0013;
        wr(32'h100, 32'h0050_0093);
        wr(32'h104, 32'h00A0_0113);
        wr(32'h108, 32'h00F0_0193);
        wr(32'h340, 32'h0030_0013);
        wr(32'h344, 32'h0040_0013);
        wr(32'h348, 32'h0050_0013);
        wr(32'h500, 32'h0010_0013);
        wr(32'h504, 32'h0020_0013);
        wr(32'h200, 32'h4585_0505);
        wr(32'h204, 32'h0060_0013);
        wr(32'h300, 32'h0093_0001);
        wr(32'h304, 32'h0FF0_0500);
        wr(32'h3F8, 32'h0093_0000);
        wr(32'h400, 32'h0070_0013);
        wr(32'h404, 32'h0080_0013);

        tbl[0]  = '{0, 0, 0, 0, 0, 0, 32'h100, 1, 0, NOP};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 32'h104, 0, 32'h100, 32'h0050_0093};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 32'h108, 0, 32'h104, 32'h00A0_0113};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 32'h108, 0, 32'h104, 32'h00A0_0113};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 32'h108, 0, 32'h104, 32'h00A0_0113};
        tbl[5]  = '{1, 0, 0, 0, 0, 0, 32'h108, 0, 32'h104, 32'h00A0_0113};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 32'h10C, 0, 32'h108, 32'h00F0_0193};
        tbl[7]  = '{0, 0, 1, 32'h600, 1, 32'h500, 32'h500, 1, 0, NOP};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 32'h504, 0, 32'h500, 32'h0010_0013};
        tbl[9]  = '{1, 1, 0, 0, 0, 0, 32'h504, 1, 0, NOP};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 32'h508, 0, 32'h504, 32'h0020_0013};
        tbl[11] = '{0, 0, 1, 32'h341, 0, 0, 32'h340, 1, 0, NOP};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 32'h344, 0, 32'h340, 32'h0030_0013};
        tbl[13] = '{0, 1, 0, 0, 0, 0, 32'h348, 1, 0, NOP};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 32'h34C, 0, 32'h348, 32'h0050_0013};

        // Reset state and fetch address during reset
        reset_i = 1'b1;
        idle();
        #1;
        chk("rst.addr", imem_addr_o, 32'h100);
        chk("rst.pc", FD_PC_o, 32'h0);
        exp_nop("rst");
        chk("rst.rvc", {31'd0, FD_isRV32C_o}, 32'd0);
        tick();
        tick();
        chk("rst.addr2", imem_addr_o, 32'h100);
        reset_i = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].st, tbl[i].fl, tbl[i].dp, tbl[i].dpt,
                  tbl[i].ec, tbl[i].ect);
            #1;
            chk($sformatf("vec%0d.addr", i), imem_addr_o, tbl[i].addr);
            tick();
            chk($sformatf("vec%0d.nop", i), {31'd0, FD_nop_o},
                {31'd0, tbl[i].nop});
            chk($sformatf("vec%0d.instr", i), FD_instr_o, tbl[i].instr);
            if (!tbl[i].nop) begin
                chk($sformatf("vec%0d.pc", i), FD_PC_o, tbl[i].pc);
                chk($sformatf("vec%0d.rvc", i), {31'd0, FD_isRV32C_o}, 32'd0);
            end
        end

`ifdef RV32C_EN
        // Two compressed parcels in one word
        drive(0, 0, 1, 32'h200, 0, 0);
        tick();
        exp_nop("c2.redir");
        idle();
        tick();
        exp_fd("c2.lo", 32'h200, 32'h0000_0505, 1);
        tick();
        exp_fd("c2.hi", 32'h202, 32'h0000_4585, 1);
        tick();
        exp_fd("c2.next", 32'h204, 32'h0060_0013, 0);

        // 32-bit instruction straddling two words
        drive(0, 0, 1, 32'h300, 0, 0);
        tick();
        exp_nop("st.redir");
        idle();
        tick();
        exp_fd("st.c", 32'h300, 32'h0000_0001, 1);
        tick();
        exp_nop("st.cap");
        tick();
        exp_fd("st.full", 32'h302, 32'h0500_0093, 0);
        tick();
        exp_fd("st.after", 32'h306, 32'h0000_0FF0, 1);

        // Redirect in the same cycle as a straddle capture
        drive(0, 0, 1, 32'h3FA, 0, 0);
        tick();
        exp_nop("rc.redir");
        drive(0, 0, 1, 32'h401, 0, 0);
        #1;
        chk("rc.addr", imem_addr_o, 32'h400);
        tick();
        exp_nop("rc.bub");
        idle();
        tick();
        exp_fd("rc.tgt", 32'h400, 32'h0070_0013, 0);
        tick();
        exp_fd("rc.next", 32'h404, 32'h0080_0013, 0);

        // Reset with a half-captured instruction
        drive(0, 0, 1, 32'h3FA, 0, 0);
        tick();
        idle();
        tick();
        exp_nop("rs.cap");
        reset_i = 1'b1;
        #1;
        exp_nop("rs.async");
        chk("rs.addr", imem_addr_o, 32'h100);
        tick();
        reset_i = 1'b0;
        tick();
        exp_nop("rs.first");
        tick();
        exp_fd("rs.w0", 32'h100, 32'h0050_0093, 0);
        tick();
        exp_fd("rs.w1", 32'h104, 32'h00A0_0113, 0);
`endif

        // ---------------- randomized run ----------------
        for (int i = 0; i < 512; i++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 1) == 0) r[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 0) r[17:16] = 2'b11;
            mem[i] = r;
        end
        reset_i = 1'b1;
        idle();
        tick();
        reset_i = 1'b0;
        model_reset();
        for (int i = 0; i < 2000; i++) begin
            bit st, fl, dp, ec;
            logic [31:0] dpt, ect;
            st  = $urandom_range(0, 99) < 20;
            fl  = $urandom_range(0, 99) < 8;
            dp  = $urandom_range(0, 99) < 5;
            ec  = $urandom_range(0, 99) < 4;
            dpt = $urandom_range(0, 32'h7FF);
            ect = $urandom_range(0, 32'h7FF);
            drive(st, fl, dp, dpt, ec, ect);
            model_step(st, fl, dp, dpt, ec, ect);
            tick();
            chk($sformatf("rnd%0d.nop", i), {31'd0, FD_nop_o}, {31'd0, e_nop});
            chk($sformatf("rnd%0d.instr", i), FD_instr_o, e_instr);
            if (!e_nop) begin
                chk($sformatf("rnd%0d.pc", i), FD_PC_o, e_pc);
                chk($sformatf("rnd%0d.rvc", i), {31'd0, FD_isRV32C_o},
                    {31'd0, e_c});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
